// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: per-channel square-wave tone synthesis feeding a 16-bit stereo
// I2S transmitter for the PMOD DAC (MCLK = clk/4, SCK = clk/16, LRCK = clk/512).
// Optional feature: define AUDIO_VOLUME_EN to add the 3-bit vol port, which
// scales the tone amplitude as AMP >> (7 - vol) (vol = 0 mutes).

// Half-period tone counter for one channel. A divider of 0 or 1 is the
// selector's rest code: the counter and phase are held cleared.
module audio_i2s_tone (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_div,
  output logic        o_phase,
  output logic        o_active
);

  logic [31:0] r_tcnt;
  logic        r_phase;
  logic        w_active;
  logic        w_wrap;

  assign w_active = (i_div > 32'd1);
  // Compare against the divider seen this cycle; a shrink below the running
  // count toggles immediately rather than wrapping through 2^32.
  assign w_wrap   = (r_tcnt >= (i_div - 32'd1));

  // Count up to div-1 and toggle the square-wave phase on each wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt  <= '0;
      r_phase <= 1'b0;
    end else if (!w_active) begin
      r_tcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_tcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_tcnt  <= r_tcnt + 32'd1;
    end
  end

  assign o_phase  = r_phase;
  assign o_active = w_active;

endmodule

module audio_i2s_tx #(
  parameter int                  SAMPLE_W = 16,
  parameter logic [SAMPLE_W-1:0] AMP      = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] note_div_l,
  input  logic [31:0] note_div_r,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]  vol,
`endif
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);

  localparam int FRAME_W = 2 * SAMPLE_W;

  logic [8:0]          r_cnt;
  logic [FRAME_W-1:0]  r_word;
  logic                r_prev_lsb;
  logic                r_sdin;

  logic                w_phase_l;
  logic                w_phase_r;
  logic                w_active_l;
  logic                w_active_r;
  logic [SAMPLE_W-1:0] w_mag;
  logic [SAMPLE_W-1:0] w_smp_l;
  logic [SAMPLE_W-1:0] w_smp_r;
  logic [8:0]          w_cnt_nxt;
  logic                w_capture;
  logic [FRAME_W-1:0]  w_word_nxt;
  logic                w_prev_nxt;
  logic [4:0]          w_slot_nxt;
  logic [4:0]          w_bit_idx;
  logic                w_sdin_nxt;

  audio_i2s_tone u_tone_l (
    .clk      (clk),
    .rst      (rst),
    .i_div    (note_div_l),
    .o_phase  (w_phase_l),
    .o_active (w_active_l)
  );

  audio_i2s_tone u_tone_r (
    .clk      (clk),
    .rst      (rst),
    .i_div    (note_div_r),
    .o_phase  (w_phase_r),
    .o_active (w_active_r)
  );

  // Amplitude magnitude; vol only matters at the frame capture because the
  // samples are consumed nowhere else.
`ifdef AUDIO_VOLUME_EN
  always_comb begin
    w_mag = '0;
    if (vol != 3'd0) begin
      w_mag = AMP >> (3'd7 - vol);
    end
  end
`else
  assign w_mag = AMP;
`endif

  // Signed square-wave samples; sign applied after any volume shift.
  always_comb begin
    w_smp_l = '0;
    w_smp_r = '0;
    if (w_active_l) begin
      w_smp_l = w_phase_l ? ({SAMPLE_W{1'b0}} - w_mag) : w_mag;
    end
    if (w_active_r) begin
      w_smp_r = w_phase_r ? ({SAMPLE_W{1'b0}} - w_mag) : w_mag;
    end
  end

  assign w_cnt_nxt  = r_cnt + 9'd1;
  assign w_capture  = (r_cnt == 9'd511);
  assign w_word_nxt = w_capture ? {w_smp_l, w_smp_r} : r_word;
  assign w_prev_nxt = w_capture ? r_word[0] : r_prev_lsb;

  // I2S one-SCK delay: slot 0 still carries the previous frame's right LSB,
  // slot n (1..31) carries word bit 32-n. Computed from next-state values so
  // the registered bit changes exactly when the slot starts (SCK falling).
  assign w_slot_nxt = w_cnt_nxt[8:4];
  assign w_bit_idx  = 5'd0 - w_slot_nxt;
  assign w_sdin_nxt = (w_slot_nxt == 5'd0) ? w_prev_nxt : w_word_nxt[w_bit_idx];

  // Frame counter, shadow frame word and serial data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_prev_lsb <= 1'b0;
      r_sdin     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_prev_lsb <= w_prev_nxt;
      r_sdin     <= w_sdin_nxt;
    end
  end

  assign audio_mclk = r_cnt[1];
  assign audio_sck  = r_cnt[3];
  assign audio_lrck = r_cnt[8];
  assign audio_sdin = r_sdin;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: expected frame words are computed from
// closed-form tone phases at each capture, queued, and compared against the
// bits collected from audio_sdin one frame later.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] note_div_l = 32'd0;
  logic [31:0] note_div_r = 32'd0;
`ifdef AUDIO_VOLUME_EN
  logic [2:0]  vol = 3'd7;
  logic [2:0]  vol_tab [4] = '{3'd7, 3'd5, 3'd0, 3'd3};
`endif
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc;
  logic [31:0] sb_q [$];
  logic [31:0] acc;

  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT frame counter state index.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  audio_i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .note_div_l (note_div_l),
    .note_div_r (note_div_r),
`ifdef AUDIO_VOLUME_EN
    .vol        (vol),
`endif
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cur_mag();
`ifdef AUDIO_VOLUME_EN
    if (vol == 3'd0) return 16'h0000;
    return 16'h2000 >> (3'd7 - vol);
`else
    return 16'h2000;
`endif
  endfunction

  function automatic logic [15:0] smp(input bit active, input int ph, input logic [15:0] m);
    if (!active) return 16'h0000;
    return ((ph % 2) != 0) ? (16'h0000 - m) : m;
  endfunction

  // Phase of each channel at state index k, in closed form per scenario:
  // 0: L=1000, R=rest; 1: L=1000, R=700; 2: L=1000 shrunk to 10 at tcnt=500.
  function automatic logic [31:0] exp_word(input int sc, input int k);
    logic [15:0] m;
    int pl, pr;
    bit al, ar;
    m  = cur_mag();
    pl = 0; pr = 0; al = 1'b1; ar = 1'b0;
    case (sc)
      0: begin pl = k / 1000; end
      1: begin pl = k / 1000; ar = 1'b1; pr = k / 700; end
      default: begin pl = (k <= 500) ? 0 : ((k - 501) / 10 + 1); end
    endcase
    return {smp(al, pl, m), smp(ar, pr, m)};
  endfunction

  task automatic do_reset(input logic [31:0] dl, input logic [31:0] dr);
    @(negedge clk);
    rst = 1'b0;
    note_div_l = dl;
    note_div_r = dr;
`ifdef AUDIO_VOLUME_EN
    vol = 3'd7;
`endif
    sb_q.delete();
    acc = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, audio_mclk, audio_lrck, audio_sck, audio_sdin}, 32'd0);
    rst = 1'b1;
  endtask

  task automatic run_frames(input int sc, input int nframes, input bit chk_clk);
    int k;
    int n;
    for (int i = 0; i < (nframes + 2) * 512; i++) begin
      @(negedge clk);
      k = cyc;
      if (chk_clk && k < 1024) begin
        check($sformatf("clk_ratio_k%0d", k), {29'd0, audio_mclk, audio_sck, audio_lrck},
              {29'd0, k[1], k[3], k[8]});
      end
      if (sc == 2 && k == 500) note_div_l = 32'd10;
`ifdef AUDIO_VOLUME_EN
      if (k % 512 == 100) vol = vol_tab[(k / 512) % 4];
`endif
      if (k % 512 == 511) sb_q.push_back(exp_word(sc, k));
      if (k >= 512 && k % 16 == 8) begin
        n = (k % 512) / 16;
        if (n != 0) begin
          acc[32 - n] = audio_sdin;
        end else if (k >= 1024) begin
          acc[0] = audio_sdin;
          vectors++;
          assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed=%0d expected=1", sb_q.size());
          end
          if (sb_q.size() != 0) begin
            check($sformatf("sc%0d_frame%0d", sc, k / 512 - 1), acc, sb_q.pop_front());
          end
        end
      end
    end
  endtask

  initial begin
    // Reset state, then a reset asserted mid-frame at cnt=300.
    do_reset(32'd1000, 32'd1);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cyc == 300) break;
    end
    check("pre_reset_cnt", cyc, 300);
    check("pre_reset_clks", {29'd0, audio_mclk, audio_sck, audio_lrck}, 32'd3);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, audio_mclk, audio_lrck, audio_sck, audio_sdin}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mclk_after_1clk", {31'd0, audio_mclk}, 32'd0);
    @(negedge clk);
    check("mclk_after_2clk", {31'd0, audio_mclk}, 32'd1);

    // Left tone, right rest; clock ratios over the first two frames.
    do_reset(32'd1000, 32'd1);
    run_frames(0, 4, 1'b1);

    // Both channels toggling; includes an L=2000/R=E000 frame.
    do_reset(32'd1000, 32'd700);
    run_frames(1, 6, 1'b0);

    // Divider shrink from 1000 to 10 while tcnt=500.
    do_reset(32'd1000, 32'd1);
    run_frames(2, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
